// File: rtl/rf_wr_arb_pkg.sv
// Shared register-file definitions: geometry, write-port controller state
// encoding and fixed requester indices.
package rf_wr_arb_pkg;

  localparam int unsigned AW   = 5;   // register address width
  localparam int unsigned DW   = 32;  // register data width
  localparam int unsigned NREG = 32;  // number of architectural registers
  localparam int unsigned IDW  = 3;   // requester index / pointer width
  localparam int unsigned CNTW = 5;   // clear-sweep counter width

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_t;

  // Requester slots on the write port
  localparam logic [IDW-1:0] WB  = 3'd0;
  localparam logic [IDW-1:0] LD  = 3'd1;
  localparam logic [IDW-1:0] DBG = 3'd2;

  // Round-robin successor of requester g among n requesters
  function automatic logic [IDW-1:0] next_ptr(input logic [IDW-1:0] g,
                                               input int unsigned   n);
    return (32'(g) == n - 1) ? '0 : g + IDW'(1);
  endfunction

endpackage

// File: rtl/rf_wr_arb_if.sv
// Requester/RF-write-port bundle for rf_wr_arb.
//   master : requester side (drives valid/addr/data/clr_start)
//   slave  : controller side (drives ready, clr_busy, RFWr/A3/WD, grant_id)
interface rf_wr_arb_if #(
  parameter int unsigned NREQ = 3,
  parameter int unsigned AW   = 5,
  parameter int unsigned DW   = 32
) ();

  logic [NREQ-1:0]                  req_valid;
  logic [NREQ*AW-1:0]               req_addr;
  logic [NREQ*DW-1:0]               req_data;
  logic [NREQ-1:0]                  req_ready;
  logic                             clr_start;
  logic                             clr_busy;
  logic                             RFWr;
  logic [AW-1:0]                    A3;
  logic [DW-1:0]                    WD;
  logic [rf_wr_arb_pkg::IDW-1:0]    grant_id;

  modport master (
    output req_valid, req_addr, req_data, clr_start,
    input  req_ready, clr_busy, RFWr, A3, WD, grant_id
  );

  modport slave (
    input  req_valid, req_addr, req_data, clr_start,
    output req_ready, clr_busy, RFWr, A3, WD, grant_id
  );

endinterface

// File: rtl/rf_wr_arb_rr_arbiter.sv
// Round-robin pick: first valid requester at or after ptr, wrapping at NREQ.
//   valid   : request vector
//   ptr     : highest-priority index (must be < NREQ)
//   grant_c : one-hot grant (zero when nothing is valid)
//   idx_c   : index of the granted requester
module rr_arbiter
  import rf_wr_arb_pkg::*;
#(
  parameter int unsigned NREQ = 3
) (
  input  logic [NREQ-1:0] valid,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant_c,
  output logic [IDW-1:0]  idx_c
);

  localparam int unsigned SW = (NREQ > 1) ? $clog2(NREQ) : 1;

  // Scan NREQ slots starting at ptr; first hit wins
  always_comb begin
    int unsigned j;
    logic        found;
    grant_c = '0;
    idx_c   = '0;
    found   = 1'b0;
    j       = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      j = 32'(ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!found && valid[SW'(j)]) begin
        found             = 1'b1;
        grant_c[SW'(j)]   = 1'b1;
        idx_c             = IDW'(j);
      end
    end
  end

endmodule

// File: rtl/rf_wr_arb.sv
// Register-file write-port controller: round-robin shares RFWr/A3/WD among
// NREQ valid/ready requesters and runs a clear sweep zeroing r1..r31.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of rf_wr_arb_if (requests, ready, RF write port,
//              clr_start/clr_busy, grant_id)
module rf_wr_arb #(
  parameter int unsigned NREQ = 3,
  parameter int unsigned AW   = rf_wr_arb_pkg::AW,
  parameter int unsigned DW   = rf_wr_arb_pkg::DW
) (
  input  logic        clk,
  input  logic        rst,
  rf_wr_arb_if.slave  bus
);

  import rf_wr_arb_pkg::*;

  localparam logic [CNTW-1:0] LAST_REG = CNTW'(NREG - 1);

  state_t          state;
  logic [IDW-1:0]  ptr;
  logic [CNTW-1:0] cnt;

  logic            rfwr_q;
  logic [AW-1:0]   a3_q;
  logic [DW-1:0]   wd_q;
  logic [IDW-1:0]  gid_q;
  logic            busy_q;

  logic [NREQ-1:0] grant_c;
  logic [IDW-1:0]  gidx_c;
  logic            open_c;
  logic            accept_c;
  logic [AW-1:0]   sel_addr_c;
  logic [DW-1:0]   sel_data_c;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .valid   (bus.req_valid),
    .ptr     (ptr),
    .grant_c (grant_c),
    .idx_c   (gidx_c)
  );

  // Requests are only offered in IDLE and lose to a clear command
  assign open_c        = (state == IDLE) && !bus.clr_start;
  assign bus.req_ready = open_c ? grant_c : '0;
  assign accept_c      = open_c && (|grant_c);

  // Payload of the granted requester
  always_comb begin
    sel_addr_c = '0;
    sel_data_c = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (grant_c[i]) begin
        sel_addr_c = bus.req_addr[i*AW +: AW];
        sel_data_c = bus.req_data[i*DW +: DW];
      end
    end
  end

  // FSM, RF write port registers and round-robin pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      ptr    <= '0;
      cnt    <= '0;
      rfwr_q <= 1'b0;
      a3_q   <= '0;
      wd_q   <= '0;
      gid_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.clr_start) begin
            state  <= SWEEP;
            cnt    <= CNTW'(2);
            rfwr_q <= 1'b1;
            a3_q   <= AW'(1);
            wd_q   <= '0;
            busy_q <= 1'b1;
          end else begin
            busy_q <= 1'b0;
            // r0 is hardwired: the handshake completes but nothing is written
            rfwr_q <= accept_c && (sel_addr_c != '0);
            if (accept_c) begin
              a3_q  <= sel_addr_c;
              wd_q  <= sel_data_c;
              gid_q <= gidx_c;
              ptr   <= next_ptr(gidx_c, NREQ);
            end
          end
        end
        SWEEP: begin
          rfwr_q <= 1'b1;
          a3_q   <= AW'(cnt);
          wd_q   <= '0;
          busy_q <= 1'b1;
          cnt    <= cnt + CNTW'(1);
          // Leave as the last register is loaded so requests overlap its cycle
          if (cnt == LAST_REG) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.RFWr     = rfwr_q;
  assign bus.A3       = a3_q;
  assign bus.WD       = wd_q;
  assign bus.grant_id = gid_q;
  assign bus.clr_busy = busy_q;

endmodule

// File: tb/tb_rf_wr_arb.sv
// Self-checking bench for rf_wr_arb: behavioural port model compared every
// cycle, plus directed scenarios with literal expectations.
module tb_rf_wr_arb;

  localparam int NR = 3;
  localparam int AWT = 5;
  localparam int DWT = 32;
  localparam int I_WB = int'(rf_wr_arb_pkg::WB);
  localparam int I_LD = int'(rf_wr_arb_pkg::LD);
  localparam int I_DBG = int'(rf_wr_arb_pkg::DBG);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rf_wr_arb_if #(.NREQ(NR), .AW(AWT), .DW(DWT)) bus ();

  rf_wr_arb #(.NREQ(NR), .AW(AWT), .DW(DWT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model of the write port ----------------
  int          m_ptr;
  int          m_sweep_next;   // next sweep address to put on the port, 0 = no sweep
  logic        e_rfwr;
  logic [4:0]  e_a3;
  logic [31:0] e_wd;
  logic [2:0]  e_gid;
  logic        e_busy;

  function automatic int model_pick();
    for (int k = 0; k < NR; k++) begin
      int j;
      j = (m_ptr + k) % NR;
      if (bus.req_valid[j]) return j;
    end
    return -1;
  endfunction

  function automatic logic [2:0] model_ready();
    int g;
    if (m_sweep_next != 0 || bus.clr_start) return 3'b000;
    g = model_pick();
    if (g < 0) return 3'b000;
    return 3'(1 << g);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ptr = 0; m_sweep_next = 0;
      e_rfwr = 1'b0; e_a3 = '0; e_wd = '0; e_gid = '0; e_busy = 1'b0;
    end else begin
      int g;
      g = model_pick();
      if (m_sweep_next != 0) begin
        e_rfwr = 1'b1; e_a3 = 5'(m_sweep_next); e_wd = '0; e_busy = 1'b1;
        m_sweep_next = (m_sweep_next == 31) ? 0 : m_sweep_next + 1;
      end else if (bus.clr_start) begin
        e_rfwr = 1'b1; e_a3 = 5'd1; e_wd = '0; e_busy = 1'b1;
        m_sweep_next = 2;
      end else if (g >= 0) begin
        e_a3   = bus.req_addr[g*AWT +: AWT];
        e_wd   = bus.req_data[g*DWT +: DWT];
        e_rfwr = (e_a3 != 0);
        e_gid  = 3'(g);
        e_busy = 1'b0;
        m_ptr  = (g + 1) % NR;
      end else begin
        e_rfwr = 1'b0; e_busy = 1'b0;
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (!rst) begin
      chk("ready",    64'(bus.req_ready), 64'(model_ready()));
      chk("RFWr",     64'(bus.RFWr),      64'(e_rfwr));
      chk("A3",       64'(bus.A3),        64'(e_a3));
      chk("WD",       64'(bus.WD),        64'(e_wd));
      chk("grant_id", 64'(bus.grant_id),  64'(e_gid));
      chk("clr_busy", 64'(bus.clr_busy),  64'(e_busy));
    end
  end

  // Register file image built from what the port writes
  logic [31:0] tb_rf [32];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) tb_rf[i] <= '0;
    end else if (bus.RFWr) begin
      tb_rf[bus.A3] <= bus.WD;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_req(input int i, input logic [4:0] a, input logic [31:0] d);
    bus.req_valid[i] = 1'b1;
    bus.req_addr[i*AWT +: AWT] = a;
    bus.req_data[i*DWT +: DWT] = d;
  endtask

  task automatic do_write(input int i, input logic [4:0] a, input logic [31:0] d);
    bit seen;
    seen = 1'b0;
    @(posedge clk); #1;
    set_req(i, a, d);
    for (int t = 0; t < 20 && !seen; t++) begin
      @(negedge clk);
      if (bus.req_ready[i]) seen = 1'b1;
      else begin @(posedge clk); #1; end
    end
    chk("write_accepted", 64'(seen), 64'd1);
    @(posedge clk); #1;
    bus.req_valid[i] = 1'b0;
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int seq [6];
    int exp_seq [6];
    int busy_cnt, zero_cnt, nz;
    bit accepted, acc_now;

    exp_seq = '{0, 1, 2, 0, 1, 2};
    bus.req_valid = '0; bus.req_addr = '0; bus.req_data = '0; bus.clr_start = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_RFWr", 64'(bus.RFWr), 64'd0);
    chk("rst_A3", 64'(bus.A3), 64'd0);
    chk("rst_WD", 64'(bus.WD), 64'd0);
    chk("rst_grant_id", 64'(bus.grant_id), 64'd0);
    chk("rst_clr_busy", 64'(bus.clr_busy), 64'd0);
    @(posedge clk); #1; rst = 1'b0;

    // Single write from the writeback port
    set_req(I_WB, 5'd5, 32'hDEADBEEF);
    @(negedge clk);
    chk("single_ready", 64'(bus.req_ready), 64'b001);
    @(posedge clk); #1; bus.req_valid = '0;
    @(negedge clk);
    chk("single_RFWr", 64'(bus.RFWr), 64'd1);
    chk("single_A3", 64'(bus.A3), 64'd5);
    chk("single_WD", 64'(bus.WD), 64'hDEADBEEF);
    chk("single_gid", 64'(bus.grant_id), 64'd0);

    // Round robin with all requesters continuously valid
    pulse_reset();
    set_req(0, 5'd1, 32'h1111_0000);
    set_req(1, 5'd2, 32'h2222_0000);
    set_req(2, 5'd3, 32'h3333_0000);
    for (int k = 0; k <= 6; k++) begin
      @(negedge clk);
      if (k < 6) seq[k] = (bus.req_ready == 3'b001) ? 0 : (bus.req_ready == 3'b010) ? 1 :
                          (bus.req_ready == 3'b100) ? 2 : -1;
      if (k > 0) begin
        chk("rr_gid", 64'(bus.grant_id), 64'(exp_seq[k-1]));
        chk("rr_no_idle", 64'(bus.RFWr), 64'd1);
      end
    end
    for (int k = 0; k < 6; k++) chk("rr_order", 64'(seq[k]), 64'(exp_seq[k]));
    @(posedge clk); #1; bus.req_valid = '0;

    // Write to r0 from the load port: handshake completes, nothing written
    @(posedge clk); #1;
    set_req(I_LD, 5'd0, 32'h0000_1234);
    @(negedge clk);
    chk("r0_ready", 64'(bus.req_ready), 64'b010);
    @(posedge clk); #1; bus.req_valid = '0;
    @(negedge clk);
    chk("r0_RFWr", 64'(bus.RFWr), 64'd0);
    chk("r0_gid", 64'(bus.grant_id), 64'd1);
    @(posedge clk); #1;
    set_req(0, 5'd4, 32'h4444_4444);
    set_req(2, 5'd6, 32'h6666_6666);
    @(negedge clk);
    chk("r0_rf0_unchanged", 64'(tb_rf[0]), 64'd0);
    chk("r0_ptr_is_2", 64'(bus.req_ready), 64'b100);
    @(posedge clk); #1; bus.req_valid[2] = 1'b0;
    @(negedge clk);
    chk("ptr_wrap_ready", 64'(bus.req_ready), 64'b001);
    chk("ptr_wrap_A3", 64'(bus.A3), 64'd6);
    @(posedge clk); #1; bus.req_valid = '0;

    // Clear sweep with the debug port requesting in the same cycle
    for (int a = 1; a < 32; a++) do_write(I_WB, 5'(a), 32'hFFFF_FFFF);
    @(posedge clk); #1;
    bus.clr_start = 1'b1;
    set_req(I_DBG, 5'd7, 32'hA5A5_0001);
    busy_cnt = 0; zero_cnt = 0; accepted = 1'b0; acc_now = 1'b0;
    for (int c = 0; c < 34; c++) begin
      @(negedge clk);
      if (bus.clr_busy) busy_cnt++;
      if (!accepted) begin
        if (bus.req_ready == '0) zero_cnt++;
        else begin
          chk("sweep_accept_cycle", 64'(c), 64'd31);
          chk("sweep_accept_ready", 64'(bus.req_ready), 64'b100);
          chk("sweep_accept_A3", 64'(bus.A3), 64'd31);
          accepted = 1'b1; acc_now = 1'b1;
        end
      end
      if (c == 32) begin
        nz = 0;
        for (int r = 0; r < 32; r++) if (tb_rf[r] != 0) nz++;
        chk("sweep_all_zero", 64'(nz), 64'd0);
      end
      if (c == 33) chk("sweep_req2_landed", 64'(tb_rf[7]), 64'hA5A5_0001);
      @(posedge clk); #1;
      bus.clr_start = 1'b0;
      if (acc_now) begin bus.req_valid[I_DBG] = 1'b0; acc_now = 1'b0; end
    end
    chk("sweep_accepted", 64'(accepted), 64'd1);
    chk("sweep_ready_zero_cycles", 64'(zero_cnt), 64'd31);
    chk("sweep_busy_cycles", 64'(busy_cnt), 64'd31);

    // clr_start during a sweep is ignored
    bus.clr_start = 1'b1;
    busy_cnt = 0;
    for (int c = 0; c < 34; c++) begin
      @(negedge clk);
      if (bus.clr_busy) busy_cnt++;
      if (c == 32) begin
        chk("ignore_end_RFWr", 64'(bus.RFWr), 64'd0);
        chk("ignore_end_busy", 64'(bus.clr_busy), 64'd0);
      end
      @(posedge clk); #1;
      bus.clr_start = (c == 9);
    end
    chk("ignore_busy_cycles", 64'(busy_cnt), 64'd31);

    // Reset in the middle of a sweep
    do_write(I_WB, 5'd9, 32'h0000_0099);
    @(posedge clk); #1;
    bus.clr_start = 1'b1;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk); #1;
      bus.clr_start = 1'b0;
    end
    rst = 1'b1;
    #1;
    chk("midrst_RFWr", 64'(bus.RFWr), 64'd0);
    chk("midrst_A3", 64'(bus.A3), 64'd0);
    chk("midrst_WD", 64'(bus.WD), 64'd0);
    chk("midrst_gid", 64'(bus.grant_id), 64'd0);
    chk("midrst_busy", 64'(bus.clr_busy), 64'd0);
    @(posedge clk); #1; rst = 1'b0;
    set_req(0, 5'd10, 32'h0A);
    set_req(1, 5'd11, 32'h0B);
    set_req(2, 5'd12, 32'h0C);
    @(negedge clk);
    chk("midrst_idle_ptr0", 64'(bus.req_ready), 64'b001);
    @(posedge clk); #1; bus.req_valid = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rf_wr_arb.md
# rf_wr_arb

Write-port controller for the 32x32 register file. Shares the single RF write port (RFWr/A3/WD) between NREQ requesters, such as core writeback, load return and debug loader, using valid/ready handshakes and round-robin arbitration. It also runs a clear sweep that zeroes r1..r31 on command. Sits between the requesters and the RF write inputs; the RF read side is untouched.

## Interface
Parameters:
- NREQ, 3, number of write requesters (2..8)
- AW, 5, register address width
- DW, 32, data width

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  NREQ  per-requester write request
- req_addr  in  NREQ*AW  packed addresses; requester i occupies bits [i*AW +: AW]
- req_data  in  NREQ*DW  packed write data; requester i occupies bits [i*DW +: DW]
- req_ready  out  NREQ  one-hot (or zero) accept; combinational
- clr_start  in  1  pulse that starts the clear sweep
- clr_busy  out  1  high while a sweep write is on the RF port
- RFWr  out  1  RF write enable; registered
- A3  out  AW  RF write address; registered
- WD  out  DW  RF write data; registered
- grant_id  out  3  index of the requester whose write is on the port; registered

## Operation
- States: IDLE, SWEEP. The sweep counter cnt is 5 bits.
- Requester handshake:
  - A requester holds valid, addr and data stable until it sees ready.
  - The transfer completes on the clock edge where valid & ready.
- IDLE with clr_start = 0:
  - The round-robin arbiter grants the first valid requester at or after pointer ptr.
  - req_ready is asserted for that requester only.
- On a handshake by requester g:
  - Output registers load RFWr = (addr != 0), A3 = addr, WD = data, grant_id = g.
  - ptr becomes (g+1) mod NREQ.
  - A write to r0 still completes the handshake and advances ptr, but RFWr stays 0.
- No handshake in a cycle: RFWr loads 0. A3, WD and grant_id hold their values.
- IDLE with clr_start = 1:
  - req_ready is all zero that cycle; clr_start wins over requests.
  - Output registers load RFWr = 1, A3 = 1, WD = 0, clr_busy = 1. cnt becomes 2 and the state moves to SWEEP.
- SWEEP:
  - req_ready is all zero.
  - Each edge loads RFWr = 1, A3 = cnt, WD = 0, and cnt increments.
  - The edge that loads A3 = 31 returns the state to IDLE. Requests may be accepted in that same cycle; they appear on the port the cycle after A3 = 31.
  - clr_start during SWEEP is ignored, with no restart and no queuing.
  - ptr is unchanged by a sweep.
- clr_busy is registered. It is high exactly for the 31 cycles in which the port carries sweep writes.
- Reset mid-sweep or mid-write aborts immediately. No partial sweep resumes.

## Timing
- Reset values: state = IDLE, ptr = 0, cnt = 0, RFWr = 0, A3 = 0, WD = 0, grant_id = 0, clr_busy = 0. req_ready then follows its combinational rule.
- Write latency:
  - Handshake at edge N puts RFWr/A3/WD on the port during cycle N+1.
  - The RF captures the write at edge N+1.
- Throughput is one write per cycle with back-to-back grants. A requester holding valid continuously is granted at least once every NREQ cycles.
- Sweep:
  - clr_start sampled at edge N gives sweep writes in cycles N+1..N+31.
  - The first request can be accepted at edge N+31 and appears in cycle N+32.
- req_ready depends combinationally on req_valid, ptr, state and clr_start. It never depends on WD or the outputs.

## Structure
- A shared package, also used by the RF and datapath, holds:
  - AW, DW and NREG = 32
  - the state encoding (IDLE, SWEEP)
  - the requester index constants (WB = 0, LD = 1, DBG = 2)
- One sub-module, rr_arbiter (NREQ-wide; inputs valid and ptr; output one-hot grant plus index), is instantiated once. The FSM, output registers and ptr update stay in rf_wr_arb.

## Test plan
- Reset, then single write: req0 writes addr 5, data 0xDEADBEEF. req_ready[0] = 1 in the same cycle. Next cycle RFWr = 1, A3 = 5, WD = 0xDEADBEEF, grant_id = 0.
- Round robin: all three valid continuously with distinct addrs 1/2/3 after reset. Grants come in order 0,1,2,0,1,2 on consecutive cycles, with no idle cycle.
- r0 write: req1 writes addr 0, data 0x1234. Handshake completes and ptr advances to 2. RFWr stays 0 and the RF is unchanged.
- Clear sweep: preload r1..r31 = 0xFFFFFFFF, then pulse clr_start with req2 valid in the same cycle.
  - req_ready = 0 for 31 cycles.
  - The port carries A3 = 1..31 with WD = 0; clr_busy is high for exactly 31 cycles.
  - req2 is accepted on the last sweep cycle.
  - All registers read 0 before req2's write lands.
- Sweep ignore and reset: pulse clr_start at sweep cycle 10. No restart occurs and the sweep ends after A3 = 31. Repeat, asserting rst at sweep cycle 15: all outputs are 0 immediately, state is IDLE and ptr = 0.
